// File: rtl/bcd_display_feeder.sv
// Iterative double-dabble binary-to-BCD converter feeding a 4-digit display; INPUT_WIDTH+1 clocks per conversion.
// Loads are ignored while busy; hex digits update only on the done pulse and saturate to 9999 with overflow.
module bcd_display_feeder #(
    parameter int INPUT_WIDTH = 16,
    parameter int MAX_VALUE   = 9999
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [INPUT_WIDTH-1:0] value,
    output logic [3:0]             hex3,
    output logic [3:0]             hex2,
    output logic [3:0]             hex1,
    output logic [3:0]             hex0,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int CW = $clog2(INPUT_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(INPUT_WIDTH - 1);
    localparam logic [INPUT_WIDTH-1:0] MAX_V = INPUT_WIDTH'(MAX_VALUE);

    typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

    state_t                 state;
    logic [INPUT_WIDTH-1:0] shift_reg;
    logic [15:0]            scratch;
    logic [15:0]            adj;
    logic [CW-1:0]          cnt;
    logic                   ovf_pending;

    // Per-nibble add-3 correction; a nibble >=5 plus 3 never exceeds 4 bits.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            hex3        <= 4'd0;
            hex2        <= 4'd0;
            hex1        <= 4'd0;
            hex0        <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_reg   <= value;
                        scratch     <= '0;
                        cnt         <= '0;
                        ovf_pending <= (value > MAX_V);
                        busy        <= 1'b1;
                        state       <= CONVERT;
                    end
                end
                CONVERT: begin
                    scratch   <= {adj[14:0], shift_reg[INPUT_WIDTH-1]};
                    shift_reg <= {shift_reg[INPUT_WIDTH-2:0], 1'b0};
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_ITER)
                        state <= FINISH;
                end
                FINISH: begin
                    // Overflowed scratch is garbage by design; only the saturated digits are shown.
                    if (ovf_pending) begin
                        hex3     <= 4'd9;
                        hex2     <= 4'd9;
                        hex1     <= 4'd9;
                        hex0     <= 4'd9;
                        overflow <= 1'b1;
                    end else begin
                        hex3     <= scratch[15:12];
                        hex2     <= scratch[11:8];
                        hex1     <= scratch[7:4];
                        hex0     <= scratch[3:0];
                        overflow <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Randomized bench for bcd_display_feeder against a decimal-arithmetic reference model.
module tb_bcd_display_feeder;

    logic        clock;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic        busy, done, overflow;

    int checks = 0;
    int errors = 0;

    // Model of what the display should currently show.
    logic [15:0] exp_hex = 16'h0000;
    logic        exp_ovf = 1'b0;

    bcd_display_feeder #(.INPUT_WIDTH(16), .MAX_VALUE(9999)) dut (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .busy(busy), .done(done), .overflow(overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_digits(input int v);
        int e;
        e = (v > 9999) ? 9999 : v;
        return {4'(e / 1000), 4'((e / 100) % 10), 4'((e / 10) % 10), 4'(e % 10)};
    endfunction

    // Starts at a negedge with the DUT idle; ends at the negedge just after the done edge.
    task automatic convert(input logic [15:0] v, input bit junk);
        logic [15:0] nxt;
        load  = 1'b1;
        value = v;
        @(posedge clock);
        for (int k = 0; k <= 16; k++) begin
            @(negedge clock);
            if (junk) begin
                load  = 1'($urandom_range(0, 1));
                value = 16'($urandom);
            end else begin
                load  = 1'b0;
            end
            check("busy_mid", {31'b0, busy}, 32'd1);
            check("done_mid", {31'b0, done}, 32'd0);
            check("hex_hold", {16'b0, hex3, hex2, hex1, hex0}, {16'b0, exp_hex});
        end
        @(negedge clock);
        load    = 1'b0;
        nxt     = ref_digits(int'(v));
        exp_hex = nxt;
        exp_ovf = (v > 16'd9999);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_end", {31'b0, busy}, 32'd0);
        check("hex_result", {16'b0, hex3, hex2, hex1, hex0}, {16'b0, exp_hex});
        check("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
    endtask

    task automatic idle(input int n);
        load = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check("idle_done", {31'b0, done}, 32'd0);
            check("idle_busy", {31'b0, busy}, 32'd0);
            check("idle_hex", {16'b0, hex3, hex2, hex1, hex0}, {16'b0, exp_hex});
            check("idle_ovf", {31'b0, overflow}, {31'b0, exp_ovf});
        end
    endtask

    initial begin
        logic [15:0] rv;
        reset = 1'b1;
        load  = 1'b0;
        value = 16'd0;
        repeat (2) @(negedge clock);
        check("reset_hex", {16'b0, hex3, hex2, hex1, hex0}, 32'd0);
        check("reset_flags", {29'b0, busy, done, overflow}, 32'd0);
        reset = 1'b0;
        idle(2);

        convert(16'd0, 1'b0);
        idle(1);
        convert(16'h04D2, 1'b0);
        idle(2);
        convert(16'd9999, 1'b0);
        convert(16'd10, 1'b0);
        idle(1);
        convert(16'd10000, 1'b0);
        convert(16'd65535, 1'b0);
        convert(16'd42, 1'b0);
        idle(1);
        convert(16'd500, 1'b1);
        idle(2);

        // Asynchronous reset mid-conversion, between clock edges.
        load  = 1'b1;
        value = 16'd8765;
        @(posedge clock);
        load = 1'b0;
        repeat (8) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("arst_hex", {16'b0, hex3, hex2, hex1, hex0}, 32'd0);
        check("arst_flags", {29'b0, busy, done, overflow}, 32'd0);
        @(negedge clock);
        reset   = 1'b0;
        exp_hex = 16'h0000;
        exp_ovf = 1'b0;
        idle(2);
        convert(16'd31, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       rv = 16'($urandom);
                1:       rv = 16'($urandom_range(9990, 10010));
                2:       rv = 16'($urandom_range(0, 99));
                default: rv = 16'($urandom_range(0, 9999));
            endcase
            convert(rv, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
